// File: rtl/sata_fis_pkg.sv
// Shared SATA FIS definitions for the transport layer.
// Holds the FIS type, command encodings, FSM states and dword packing.
package sata_fis_pkg;

    localparam logic [7:0] FIS_REG_H2D  = 8'h27;
    localparam logic [2:0] CMD_REG_CMD  = 3'd1;
    localparam logic [2:0] CMD_REG_CTRL = 3'd2;
    localparam int         FIS_DWORDS   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } tx_state_t;

    typedef struct packed {
        logic [15:0] feature;
        logic [47:0] lba;
        logic [15:0] count;
        logic [7:0]  command;
        logic [7:0]  dev;
        logic [7:0]  control;
        logic [3:0]  port;
        logic        c_bit;
    } reg_snap_t;

    function automatic logic [31:0] fis_dword(
        input reg_snap_t  s,
        input logic [2:0] idx
    );
        logic [31:0] dw;
        dw = '0;
        case (idx)
            3'd0:    dw = {s.feature[7:0], s.command, s.c_bit, 3'b000,
                           s.port, FIS_REG_H2D};
            3'd1:    dw = {s.dev, s.lba[23:0]};
            3'd2:    dw = {s.feature[15:8], s.lba[47:24]};
            3'd3:    dw = {s.control, 8'h00, s.count};
            default: dw = '0;
        endcase
        return dw;
    endfunction

endpackage

// File: rtl/tl_reg_fis_tx.sv
// Register H2D FIS transmitter between command layer and link layer.
// Snapshots a request, sends five dwords, retries and watches for completion.
module tl_reg_fis_tx
    import sata_fis_pkg::*;
#(
    parameter int MAX_RETRIES = 3,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  cmd_type,
    input  logic        cmd_val,
    input  logic [3:0]  cmd_port,
    output logic        cmd_busy,
    output logic        cmd_done_good,
    output logic        cmd_done_bad,
    input  logic [15:0] sh_feature_in,
    input  logic [47:0] sh_lba_in,
    input  logic [15:0] sh_count_in,
    input  logic [7:0]  sh_command_in,
    input  logic [7:0]  sh_dev_in,
    input  logic [7:0]  sh_control_in,
    output logic        ll_frame_req,
    input  logic        ll_frame_ack,
    output logic [31:0] ll_data_out,
    output logic        ll_data_val_out,
    output logic        ll_data_last_out,
    input  logic        ll_data_strobe_in,
    input  logic        ll_xmit_good,
    input  logic        ll_xmit_bad
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [15:0]   WDOG_LIM  = 16'(WDOG_CYCLES);
    localparam logic [2:0]    LAST_IDX  = 3'(FIS_DWORDS - 1);

    tx_state_t     state_q, state_n;
    reg_snap_t     snap_q;
    logic [2:0]    idx_q, idx_n;
    logic [RW-1:0] retry_q, retry_n;
    logic [15:0]   wdog_q, wdog_n;
    logic          type_ok;
    logic          accept;
    logic          reject;
    logic          fin_good;
    logic          fin_bad;
    logic          fail;

    assign type_ok = (cmd_type == CMD_REG_CMD) ||
                     (cmd_type == CMD_REG_CTRL);

    // Next state, dword index, retry and watchdog decode
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        retry_n  = retry_q;
        wdog_n   = wdog_q;
        accept   = 1'b0;
        reject   = 1'b0;
        fin_good = 1'b0;
        fin_bad  = 1'b0;
        fail     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_n = ST_IDLE;
                if (cmd_val && type_ok) begin
                    accept  = 1'b1;
                    retry_n = '0;
                    state_n = ST_REQ;
                end else if (cmd_val) begin
                    reject = 1'b1;
                end
            end
            ST_REQ: begin
                if (ll_frame_ack) begin
                    idx_n   = '0;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ll_data_strobe_in) begin
                    if (idx_q == LAST_IDX) begin
                        wdog_n  = '0;
                        state_n = ST_WAIT;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (wdog_q != 16'hFFFF) begin
                    wdog_n = wdog_q + 16'd1;
                end
                fail = ll_xmit_bad || (wdog_q == WDOG_LIM);
                if (fail && (retry_q < RETRY_MAX)) begin
                    retry_n = retry_q + RW'(1);
                    state_n = ST_REQ;
                end else if (fail) begin
                    fin_bad = 1'b1;
                    state_n = ST_DONE;
                end else if (ll_xmit_good) begin
                    fin_good = 1'b1;
                    state_n  = ST_DONE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and per-command counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            retry_q <= retry_n;
            wdog_q  <= wdog_n;
        end
    end

    // Request snapshot, held unchanged across all attempts
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q <= '0;
        end else if (accept) begin
            snap_q <= '{feature: sh_feature_in,
                        lba:     sh_lba_in,
                        count:   sh_count_in,
                        command: sh_command_in,
                        dev:     sh_dev_in,
                        control: sh_control_in,
                        port:    cmd_port,
                        c_bit:   (cmd_type == CMD_REG_CMD)};
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_busy         <= 1'b0;
            cmd_done_good    <= 1'b0;
            cmd_done_bad     <= 1'b0;
            ll_frame_req     <= 1'b0;
            ll_data_val_out  <= 1'b0;
            ll_data_last_out <= 1'b0;
            ll_data_out      <= '0;
        end else begin
            cmd_busy         <= (state_n == ST_REQ) ||
                                (state_n == ST_SEND) ||
                                (state_n == ST_WAIT);
            cmd_done_good    <= fin_good;
            cmd_done_bad     <= fin_bad || reject;
            ll_frame_req     <= (state_n == ST_REQ);
            ll_data_val_out  <= (state_n == ST_SEND);
            ll_data_last_out <= (state_n == ST_SEND) &&
                                (idx_n == LAST_IDX);
            ll_data_out      <= (state_n == ST_SEND) ?
                                fis_dword(snap_q, idx_n) : 32'h0;
        end
    end

endmodule

// File: tb/tb_tl_reg_fis_tx.sv
// Scoreboard bench for tl_reg_fis_tx with a randomized link-layer responder.
// Expected dwords and completions are queued at stimulus time and popped by a monitor.
module tb_tl_reg_fis_tx;

    localparam int MAXR = 3;
    localparam int WDOG = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cmd_type;
    logic        cmd_val;
    logic [3:0]  cmd_port;
    logic        cmd_busy;
    logic        cmd_done_good;
    logic        cmd_done_bad;
    logic [15:0] sh_feature_in;
    logic [47:0] sh_lba_in;
    logic [15:0] sh_count_in;
    logic [7:0]  sh_command_in;
    logic [7:0]  sh_dev_in;
    logic [7:0]  sh_control_in;
    logic        ll_frame_req;
    logic        ll_frame_ack;
    logic [31:0] ll_data_out;
    logic        ll_data_val_out;
    logic        ll_data_last_out;
    logic        ll_data_strobe_in;
    logic        ll_xmit_good;
    logic        ll_xmit_bad;

    tl_reg_fis_tx #(
        .MAX_RETRIES(MAXR),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_type         (cmd_type),
        .cmd_val          (cmd_val),
        .cmd_port         (cmd_port),
        .cmd_busy         (cmd_busy),
        .cmd_done_good    (cmd_done_good),
        .cmd_done_bad     (cmd_done_bad),
        .sh_feature_in    (sh_feature_in),
        .sh_lba_in        (sh_lba_in),
        .sh_count_in      (sh_count_in),
        .sh_command_in    (sh_command_in),
        .sh_dev_in        (sh_dev_in),
        .sh_control_in    (sh_control_in),
        .ll_frame_req     (ll_frame_req),
        .ll_frame_ack     (ll_frame_ack),
        .ll_data_out      (ll_data_out),
        .ll_data_val_out  (ll_data_val_out),
        .ll_data_last_out (ll_data_last_out),
        .ll_data_strobe_in(ll_data_strobe_in),
        .ll_xmit_good     (ll_xmit_good),
        .ll_xmit_bad      (ll_xmit_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  typ;
        logic [3:0]  port;
        logic [15:0] feat;
        logic [47:0] lba;
        logic [15:0] cnt;
        logic [7:0]  cmd;
        logic [7:0]  dev;
        logic [7:0]  ctl;
    } req_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t exp_dw[$];
    bit   exp_done[$];
    int   checks = 0;
    int   passed = 0;

    function automatic void check(input string name,
                                  input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Reference FIS layout built with plain arithmetic on the request fields
    function automatic logic [31:0] ref_dw(input req_t r, input int i);
        logic [31:0] c;
        logic [31:0] lo;
        logic [31:0] hi;
        c  = (r.typ == 3'd1) ? 32'd1 : 32'd0;
        lo = 32'(r.lba % 48'h100_0000);
        hi = 32'(r.lba / 48'h100_0000);
        case (i)
            0: return 32'(r.feat % 16'h100) * 32'h100_0000 +
                      32'(r.cmd) * 32'h1_0000 + c * 32'h8000 +
                      32'(r.port) * 32'h100 + 32'h27;
            1: return 32'(r.dev) * 32'h100_0000 + lo;
            2: return 32'(r.feat / 16'h100) * 32'h100_0000 + hi;
            3: return 32'(r.ctl) * 32'h100_0000 + 32'(r.cnt);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [37:0] outs();
        return {cmd_busy, cmd_done_good, cmd_done_bad, ll_frame_req,
                ll_data_val_out, ll_data_last_out, ll_data_out};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT transfers or completes
    initial begin
        exp_t e;
        bit   g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("last_needs_val",
                      ll_data_last_out & ~ll_data_val_out, 0);
                if (ll_data_val_out && ll_data_strobe_in) begin
                    if (exp_dw.size() == 0) begin
                        check("unexpected_dword", 1, 0);
                    end else begin
                        e = exp_dw.pop_front();
                        check("dword", ll_data_out, e.d);
                        check("last_flag", ll_data_last_out, e.l);
                    end
                end
                if (cmd_done_good || cmd_done_bad) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done",
                              {cmd_done_good, cmd_done_bad}, 0);
                    end else begin
                        g = exp_done.pop_front();
                        check("done_kind", {cmd_done_good, cmd_done_bad},
                              g ? 2'b10 : 2'b01);
                        check("busy_at_done", cmd_busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic scramble();
        sh_feature_in = 16'($urandom);
        sh_lba_in     = {16'($urandom), $urandom};
        sh_count_in   = 16'($urandom);
        sh_command_in = 8'($urandom);
        sh_dev_in     = 8'($urandom);
        sh_control_in = 8'($urandom);
        cmd_port      = 4'($urandom);
        cmd_type      = 3'($urandom);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after acceptance
    task automatic issue(input req_t r);
        cmd_type      = r.typ;
        cmd_port      = r.port;
        sh_feature_in = r.feat;
        sh_lba_in     = r.lba;
        sh_count_in   = r.cnt;
        sh_command_in = r.cmd;
        sh_dev_in     = r.dev;
        sh_control_in = r.ctl;
        cmd_val       = 1'b1;
        @(posedge clk); #1;
        cmd_val = 1'b0;
        scramble();
        @(negedge clk);
    endtask

    // resp: 2 bits per attempt, 0=good 1=bad 2=good+bad 3=silent
    task automatic run_cmd(input req_t r, input logic [7:0] resp,
                           input bit stall, input bit poke);
        int na;
        bit good;
        int k;
        int cnt;
        int hold;
        int d;
        logic [1:0] rc;
        na   = MAXR + 1;
        good = 1'b0;
        for (int i = MAXR; i >= 0; i--) begin
            if (resp[2*i +: 2] == 2'd0) begin
                na   = i + 1;
                good = 1'b1;
            end
        end
        issue(r);
        check("busy_after_accept", cmd_busy, 1);
        check("req_after_accept", ll_frame_req, 1);
        for (int a = 0; a < na; a++) begin
            for (int j = 0; j < 5; j++) exp_dw.push_back('{ref_dw(r, j), j == 4});
            if (a == na - 1) exp_done.push_back(good);
            k = 0;
            while (!ll_frame_req && k < 20) begin
                @(negedge clk);
                k++;
            end
            check("frame_req", ll_frame_req, 1);
            d = $urandom_range(0, 2);
            repeat (d) begin
                @(posedge clk); #1;
                ll_xmit_good = ($urandom_range(0, 3) == 0);
                ll_xmit_bad  = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            ll_xmit_good = 1'b0;
            ll_xmit_bad  = 1'b0;
            ll_frame_ack = 1'b1;
            @(posedge clk); #1;
            ll_frame_ack = 1'b0;
            cnt  = 0;
            hold = 0;
            k    = 0;
            while (cnt < 5 && k < 100) begin
                if (stall && cnt == 2 && hold < 3) begin
                    ll_data_strobe_in = 1'b0;
                    hold++;
                end else begin
                    ll_data_strobe_in = ($urandom_range(0, 3) != 0);
                end
                ll_xmit_bad = ($urandom_range(0, 7) == 0);
                @(negedge clk);
                if (k == 0) check("dw0_after_ack", ll_data_val_out, 1);
                if (!ll_data_strobe_in)
                    check("dword_held",
                          {ll_data_val_out, ll_data_last_out, ll_data_out},
                          {1'b1, (cnt == 4), ref_dw(r, cnt)});
                if (ll_data_val_out && ll_data_strobe_in) cnt++;
                k++;
                @(posedge clk); #1;
            end
            check("frame_complete", cnt, 5);
            ll_data_strobe_in = 1'b0;
            ll_xmit_bad       = 1'b0;
            rc = resp[2*a +: 2];
            if (rc == 2'd3) begin
                k = 0;
                @(negedge clk);
                while (!ll_frame_req && cmd_busy && k < WDOG + 10) begin
                    @(negedge clk);
                    k++;
                end
                check("wdog_window", (k >= WDOG - 1) && (k <= WDOG + 2), 1);
                if (a == na - 1) check("wdog_done_bad", cmd_done_bad, 1);
                else check("wdog_retry_req", ll_frame_req, 1);
            end else begin
                if (poke && a == 0) begin
                    cmd_type  = 3'd1;
                    sh_lba_in = {16'($urandom), $urandom};
                    cmd_val   = 1'b1;
                    @(posedge clk); #1;
                    cmd_val = 1'b0;
                end
                d = $urandom_range(0, 3);
                repeat (d) begin
                    @(posedge clk); #1;
                end
                ll_xmit_good = (rc == 2'd0) || (rc == 2'd2);
                ll_xmit_bad  = (rc == 2'd1) || (rc == 2'd2);
                @(posedge clk); #1;
                ll_xmit_good = 1'b0;
                ll_xmit_bad  = 1'b0;
                @(negedge clk);
                if (a == na - 1) begin
                    check("done_k1", {cmd_done_good, cmd_done_bad},
                          good ? 2'b10 : 2'b01);
                    check("busy_k1", cmd_busy, 0);
                end else begin
                    check("retry_req_k1", ll_frame_req, 1);
                end
            end
        end
    endtask

    task automatic run_reject(input logic [2:0] t);
        cmd_type = t;
        cmd_val  = 1'b1;
        exp_done.push_back(1'b0);
        @(posedge clk); #1;
        cmd_val = 1'b0;
        @(negedge clk);
        check("reject_done_bad", cmd_done_bad, 1);
        check("reject_no_busy", cmd_busy, 0);
        check("reject_no_req", ll_frame_req, 0);
        @(negedge clk);
        check("reject_idle_after", {cmd_busy, ll_frame_req, cmd_done_bad}, 0);
    endtask

    task automatic run_reset(input req_t r);
        int cnt;
        int k;
        issue(r);
        for (int j = 0; j < 5; j++) exp_dw.push_back('{ref_dw(r, j), j == 4});
        @(posedge clk); #1;
        ll_frame_ack = 1'b1;
        @(posedge clk); #1;
        ll_frame_ack      = 1'b0;
        ll_data_strobe_in = 1'b1;
        cnt = 0;
        k   = 0;
        while (cnt < 2 && k < 20) begin
            @(negedge clk);
            if (ll_data_val_out && ll_data_strobe_in) cnt++;
            k++;
            @(posedge clk); #1;
        end
        ll_data_strobe_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("dw2_before_reset", ll_data_out, ref_dw(r, 2));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_dw.delete();
        @(negedge clk);
        check("outputs_after_midframe_reset", outs(), 0);
        repeat (5) @(negedge clk);
        check("idle_after_reset", {cmd_busy, ll_frame_req, ll_data_val_out}, 0);
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.typ  = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
        r.port = 4'($urandom);
        r.feat = 16'($urandom);
        r.lba  = {16'($urandom), $urandom};
        r.cnt  = 16'($urandom);
        r.cmd  = 8'($urandom);
        r.dev  = 8'($urandom);
        r.ctl  = 8'($urandom);
        return r;
    endfunction

    function automatic logic [7:0] rand_resp();
        logic [7:0] v;
        int x;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            x = $urandom_range(0, 19);
            if (x < 10)      v[2*i +: 2] = 2'd0;
            else if (x < 16) v[2*i +: 2] = 2'd1;
            else if (x < 19) v[2*i +: 2] = 2'd2;
            else             v[2*i +: 2] = 2'd3;
        end
        return v;
    endfunction

    initial begin
        req_t tp;
        req_t cr;
        rst               = 1'b1;
        cmd_val           = 1'b0;
        cmd_type          = 3'd0;
        cmd_port          = 4'd0;
        sh_feature_in     = '0;
        sh_lba_in         = '0;
        sh_count_in       = '0;
        sh_command_in     = '0;
        sh_dev_in         = '0;
        sh_control_in     = '0;
        ll_frame_ack      = 1'b0;
        ll_data_strobe_in = 1'b0;
        ll_xmit_good      = 1'b0;
        ll_xmit_bad       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("outputs_in_reset", outs(), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("outputs_after_reset", outs(), 0);

        tp = '{typ: 3'd1, port: 4'd5, feat: 16'h0000,
               lba: 48'h0000_1234_5678, cnt: 16'h0008,
               cmd: 8'h25, dev: 8'h40, ctl: 8'h00};
        run_cmd(tp, 8'b00_00_00_00, 1'b0, 1'b0);
        run_cmd(tp, 8'b00_00_00_00, 1'b1, 1'b0);
        run_cmd(tp, 8'b00_01_01_01, 1'b0, 1'b0);
        run_cmd(tp, 8'b01_01_01_01, 1'b0, 1'b0);
        run_reject(3'd5);
        run_reject(3'd0);
        run_reject(3'd7);
        cr = '{typ: 3'd2, port: 4'hA, feat: 16'hABCD,
               lba: 48'hFEDC_BA98_7654, cnt: 16'h1234,
               cmd: 8'hEC, dev: 8'hE0, ctl: 8'h0C};
        run_cmd(cr, 8'b00_00_00_10, 1'b0, 1'b1);
        run_cmd(tp, 8'b10_10_10_10, 1'b0, 1'b0);
        run_cmd(cr, 8'b00_00_00_11, 1'b0, 1'b0);
        run_cmd(tp, 8'b11_11_11_11, 1'b0, 1'b0);
        run_reset(tp);
        run_cmd(tp, 8'b00_00_00_00, 1'b0, 1'b0);
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 5) == 0) run_reject(3'($urandom_range(3, 7)));
            run_cmd(rand_req(), rand_resp(),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (3) @(negedge clk);
        check("dword_queue_empty", exp_dw.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
